// File: rtl/bram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arb
// Description : Two-requester round-robin arbiter for a single 36-bit BRAM
//               port, with optional zero-fill of the BRAM after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arb #(
    parameter int ADDR_W  = 10,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              r0_req,
    input  logic [3:0]        r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [3:0]        r0_wpar,
    input  logic              r1_req,
    input  logic [3:0]        r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r1_wpar,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [31:0]       r0_rdata,
    output logic [3:0]        r0_rpar,
    output logic [31:0]       r1_rdata,
    output logic [3:0]        r1_rpar,
    output logic              init_done,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [15:0]       bram_addr,
    output logic [31:0]       bram_di,
    output logic [3:0]        bram_dip,
    input  logic [31:0]       bram_do,
    input  logic [3:0]        bram_dop
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = '1;
    localparam state_t            C_RST_STATE = INIT_EN ? ST_INIT : ST_RUN;
    localparam logic              C_RST_DONE  = INIT_EN ? 1'b0 : 1'b1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_last;      // 1 when r1 held the most recent grant
    logic                r_tag0;
    logic                r_tag1;
    logic                r_init_done;

    logic                w_run;
    logic                w_init;
    logic                w_gnt0;
    logic                w_gnt1;
    logic [ADDR_W-1:0]   w_word;

    // Reset gates everything combinationally so nothing leaks out while RST is high
    assign w_run  = (r_state == ST_RUN)  & ~RST;
    assign w_init = (r_state == ST_INIT) & ~RST;

    assign w_gnt0 = w_run & r0_req & (~r1_req |  r_last);
    assign w_gnt1 = w_run & r1_req & (~r0_req | ~r_last);

    always_comb begin
        bram_en  = 1'b0;
        bram_we  = 4'h0;
        w_word   = '0;
        bram_di  = 32'h0;
        bram_dip = 4'h0;
        if (w_init) begin
            bram_en = 1'b1;
            bram_we = 4'hF;
            w_word  = r_cnt;
        end else if (w_gnt0) begin
            bram_en  = 1'b1;
            bram_we  = r0_we;
            w_word   = r0_addr;
            bram_di  = r0_wdata;
            bram_dip = r0_wpar;
        end else if (w_gnt1) begin
            bram_en  = 1'b1;
            bram_we  = r1_we;
            w_word   = r1_addr;
            bram_di  = r1_wdata;
            bram_dip = r1_wpar;
        end
    end

    assign bram_addr = {{(11 - ADDR_W){1'b0}}, w_word, 5'b0_0000};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= C_RST_STATE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_tag0      <= 1'b0;
            r_tag1      <= 1'b0;
            r_init_done <= C_RST_DONE;
        end else begin
            r_tag0 <= w_gnt0 & (r0_we == 4'h0);
            r_tag1 <= w_gnt1 & (r1_we == 4'h0);
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
            if (r_state == ST_INIT) begin
                // Counter holds at the top address; leaving INIT ends the fill
                if (r_cnt == C_LAST_ADDR) begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign r0_gnt    = w_gnt0;
    assign r1_gnt    = w_gnt1;
    assign r0_rvalid = r_tag0 & ~RST;
    assign r1_rvalid = r_tag1 & ~RST;
    assign r0_rdata  = bram_do;
    assign r0_rpar   = bram_dop;
    assign r1_rdata  = bram_do;
    assign r1_rpar   = bram_dop;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arb
// Description : Self-checking bench for bram_port_arb against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arb;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic              r0_req, r1_req;
    logic [3:0]        r0_we, r1_we;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [31:0]       r0_wdata, r1_wdata;
    logic [3:0]        r0_wpar, r1_wpar;
    logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [31:0]       r0_rdata, r1_rdata;
    logic [3:0]        r0_rpar, r1_rpar;
    logic              init_done, bram_en;
    logic [3:0]        bram_we, bram_dip, bram_dop;
    logic [15:0]       bram_addr;
    logic [31:0]       bram_di, bram_do;

    bram_port_arb #(.ADDR_W(ADDR_W), .INIT_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wpar(r0_wpar),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wpar(r1_wpar),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r0_rpar(r0_rpar), .r1_rdata(r1_rdata), .r1_rpar(r1_rpar),
        .init_done(init_done), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_di(bram_di), .bram_dip(bram_dip), .bram_do(bram_do), .bram_dop(bram_dop)
    );

    // BRAM: {parity, data} words, byte-masked write, 1-cycle read
    logic [35:0] bmem [DEPTH];
    logic [35:0] brd;
    logic [35:0] bw;
    always @(posedge CLK) begin
        if (bram_en) begin
            brd <= bmem[bram_addr[ADDR_W+4:5]];
            bw = bmem[bram_addr[ADDR_W+4:5]];
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) begin
                    bw[8*b +: 8] = bram_di[8*b +: 8];
                    bw[32+b]     = bram_dip[b];
                end
            end
            bmem[bram_addr[ADDR_W+4:5]] <= bw;
        end
    end
    assign bram_do  = brd[31:0];
    assign bram_dop = brd[35:32];

    // Reference model state
    logic [35:0] ref_mem [DEPTH];
    bit          in_init = 1'b1;
    int          fill = 0;
    int          last = 1;
    bit          pend = 1'b0;
    int          pend_who = 0;
    logic [35:0] pend_data = '0;
    bit          g0 = 1'b0, g1 = 1'b0;
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] merge(input logic [35:0] old, input logic [3:0] we,
                                          input logic [31:0] d, input logic [3:0] p);
        logic [35:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                r[8*b +: 8] = d[8*b +: 8];
                r[32+b]     = p[b];
            end
        end
        return r;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, return after the rising edge
    task automatic cycle();
        int          who;
        logic [3:0]  we;
        int          a;
        logic [31:0] d;
        logic [3:0]  p;
        @(negedge CLK);
        who = -1; we = 4'h0; a = 0; d = '0; p = '0;
        if (RST) begin
            chk("rst_gnt", {r1_gnt, r0_gnt}, 2'b00);
            chk("rst_en", bram_en, 1'b0);
            chk("rst_we", bram_we, 4'h0);
            chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
        end else if (in_init) begin
            chk("init_gnt", {r1_gnt, r0_gnt}, 2'b00);
            chk("init_en_we", {bram_en, bram_we}, 5'h1F);
            chk("init_addr", bram_addr, 36'(fill * 32));
            chk("init_data", {bram_dip, bram_di}, 36'h0);
            chk("init_done_lo", init_done, 1'b0);
            chk("init_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
        end else begin
            if (r0_req && r1_req) who = (last == 1) ? 0 : 1;
            else if (r0_req)      who = 0;
            else if (r1_req)      who = 1;
            if (who == 0) begin we = r0_we; a = int'(r0_addr); d = r0_wdata; p = r0_wpar; end
            if (who == 1) begin we = r1_we; a = int'(r1_addr); d = r1_wdata; p = r1_wpar; end
            chk("gnt", {r1_gnt, r0_gnt}, {who == 1, who == 0});
            chk("en", bram_en, who >= 0);
            chk("we", bram_we, we);
            chk("addr", bram_addr, 36'(a * 32));
            chk("wdata", {bram_dip, bram_di}, {p, d});
            chk("init_done_hi", init_done, 1'b1);
            chk("rvalid", {r1_rvalid, r0_rvalid}, {pend && pend_who == 1, pend && pend_who == 0});
            if (pend && pend_who == 0) chk("r0_rdata", {r0_rpar, r0_rdata}, pend_data);
            if (pend && pend_who == 1) chk("r1_rdata", {r1_rpar, r1_rdata}, pend_data);
            chk("mirror", {r1_rpar, r1_rdata, r0_rpar, r0_rdata}, {2{bram_dop, bram_do}});
        end
        g0 = (who == 0);
        g1 = (who == 1);
        if (RST) begin
            in_init = 1'b1; fill = 0; last = 1; pend = 1'b0;
        end else if (in_init) begin
            ref_mem[fill] = '0;
            fill++;
            if (fill == DEPTH) in_init = 1'b0;
            pend = 1'b0;
        end else begin
            if (who >= 0) begin
                last = who;
                if (we != 4'h0) ref_mem[a] = merge(ref_mem[a], we, d, p);
            end
            pend      = (who >= 0) && (we == 4'h0);
            pend_who  = who;
            pend_data = (who >= 0) ? ref_mem[a] : '0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_r0(input logic req, input logic [3:0] we, input int a,
                          input logic [31:0] d, input logic [3:0] p);
        r0_req = req; r0_we = we; r0_addr = ADDR_W'(a); r0_wdata = d; r0_wpar = p;
    endtask

    initial begin
        bit did_rst;
        for (int i = 0; i < DEPTH; i++) bmem[i] = {4'($urandom), 32'($urandom)};
        RST = 1'b1;
        set_r0(1'b1, 4'h0, 1, 32'h0, 4'h0);
        r1_req = 1'b1; r1_we = 4'h0; r1_addr = 10'd2; r1_wdata = '0; r1_wpar = '0;
        repeat (2) cycle();
        RST = 1'b0;

        // Zero-fill with both requests pending, then round-robin on entry to RUN
        for (int k = 0; k < DEPTH + 10 && in_init; k++) cycle();
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("rr_seq", {r1_gnt, r0_gnt}, (i % 2) ? 2'b10 : 2'b01);
            cycle();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        cycle();

        // Write then read back
        set_r0(1'b1, 4'hF, 'h055, 32'hDEADBEEF, 4'hA);
        cycle();
        r0_we = 4'h0;
        cycle();
        r0_req = 1'b0;
        #2;
        chk("rd_055", {r0_rvalid, r1_rvalid, r0_rpar, r0_rdata}, {2'b10, 4'hA, 32'hDEADBEEF});
        cycle();

        // Partial byte write
        set_r0(1'b1, 4'hF, 3, 32'h11223344, 4'h0);
        cycle();
        set_r0(1'b1, 4'b0010, 3, 32'hFFFFAAFF, 4'hF);
        cycle();
        r0_we = 4'h0;
        cycle();
        r0_req = 1'b0;
        #2;
        chk("rd_partial", {r0_rvalid, r0_rpar, r0_rdata}, {1'b1, 4'h2, 32'h1122AA44});
        cycle();

        // Random traffic; a requester keeps its fields until granted
        for (int n = 0; n < 400; n++) begin
            if (!r0_req || g0)
                set_r0($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
                       int'($urandom_range(0, 15)), $urandom, 4'($urandom));
            if (!r1_req || g1) begin
                r1_req = ($urandom_range(0, 3) != 0);
                r1_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
                r1_addr = ADDR_W'($urandom_range(0, 15));
                r1_wdata = $urandom; r1_wpar = 4'($urandom);
            end
            cycle();
        end

        // Read grant followed by reset: the pending rvalid must be dropped
        r0_req = 1'b0;
        r1_req = 1'b1; r1_we = 4'h0; r1_addr = 10'd7;
        cycle();
        RST = 1'b1; r1_req = 1'b0;
        cycle();
        RST = 1'b0;

        // Refill with a one-cycle reset at counter 500
        did_rst = 1'b0;
        for (int k = 0; k < 3 * DEPTH && in_init; k++) begin
            if (fill == 500 && !did_rst) begin
                RST = 1'b1;
                cycle();
                RST = 1'b0;
                did_rst = 1'b1;
            end else begin
                cycle();
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_r0(1'b1, 4'h0, i * 5, 32'h0, 4'h0);
            cycle();
        end
        r0_req = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
